// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value,
// the four round helper functions and the compression FSM state type.
package sha256_pkg;

   localparam int SHA_DW     = 32;
   localparam int SHA_ROUNDS = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_ADD   = 2'd2
   } state_e;

   // Working variables a..h; a sits in the top word so the packed layout
   // matches the H0..H7 ordering of the hash bus.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Hash-RAM / scheduler side bus of the compression core.
// master = block controller (drives start, hash, schedule words),
// slave  = compression core.
interface sha256_compress_if
   import sha256_pkg::*;
#(
   parameter int DATA_WIDTH = SHA_DW
) ();

   logic                      i_start;
   logic [8*DATA_WIDTH-1:0]   i_hash;
   logic [DATA_WIDTH-1:0]     i_w;
   logic                      i_w_valid;
   logic                      o_w_ready;
   logic [5:0]                o_round;
   logic [8*DATA_WIDTH-1:0]   o_hash;
   logic                      o_hash_we;
   logic                      o_busy;
   logic                      o_done;

   modport master (
      output i_start, i_hash, i_w, i_w_valid,
      input  o_w_ready, o_round, o_hash, o_hash_we, o_busy, o_done
   );

   modport slave (
      input  i_start, i_hash, i_w, i_w_valid,
      output o_w_ready, o_round, o_hash, o_hash_we, o_busy, o_done
   );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: (a..h, K_t, W_t) -> next a..h.
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       i_work,
   input  logic [31:0] i_k,
   input  logic [31:0] i_w,
   output work_t       o_work
);

   logic [31:0] t1;
   logic [31:0] t2;

   // Compute T1/T2 and rotate the working variables down by one slot.
   always_comb begin
      t1 = i_work.h + big_sigma1(i_work.e) + ch(i_work.e, i_work.f, i_work.g) + i_k + i_w;
      t2 = big_sigma0(i_work.a) + maj(i_work.a, i_work.b, i_work.c);
      o_work.a = t1 + t2;
      o_work.b = i_work.a;
      o_work.c = i_work.b;
      o_work.d = i_work.c;
      o_work.e = i_work.d + t1;
      o_work.f = i_work.e;
      o_work.g = i_work.f;
      o_work.h = i_work.g;
   end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per accepted schedule word,
// then a final add into H and a one-cycle hash RAM write strobe.
module sha256_compress
   import sha256_pkg::*;
#(
   parameter int DATA_WIDTH = SHA_DW,
   parameter int ROUNDS     = SHA_ROUNDS
) (
   input  logic             clk,
   input  logic             rst_n,
   sha256_compress_if.slave bus
);

   localparam int         WORDS      = 8;
   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   state_e                     state_q, state_d;
   logic [5:0]                 t_q, t_d;
   work_t                      work_q, work_d;
   work_t                      h_q, h_d;
   work_t                      round_out;
   logic [WORDS*DATA_WIDTH-1:0] hash_q, hash_d;
   logic [WORDS*DATA_WIDTH-1:0] hash_sum;
   logic                       we_q, we_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;
   logic                       ready_q, ready_d;

   sha256_round u_round (
      .i_work (work_q),
      .i_k    (K[t_q]),
      .i_w    (bus.i_w),
      .o_work (round_out)
   );

   // Final feed-forward: each H word plus its working variable, mod 2^32.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_add
         assign hash_sum[DATA_WIDTH*(WORDS-gi)-1 -: DATA_WIDTH] =
            h_q[DATA_WIDTH*(WORDS-gi)-1 -: DATA_WIDTH] + work_q[DATA_WIDTH*(WORDS-gi)-1 -: DATA_WIDTH];
      end
   endgenerate

   // Next-state logic for the IDLE -> ROUND -> ADD sequence.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      work_d  = work_q;
      h_d     = h_q;
      hash_d  = hash_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      busy_d  = busy_q;
      ready_d = ready_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               h_d     = work_t'(bus.i_hash);
               work_d  = work_t'(bus.i_hash);
               t_d     = 6'd0;
               state_d = ST_ROUND;
               busy_d  = 1'b1;
               ready_d = 1'b1;
            end
         end
         ST_ROUND: begin
            // A low valid is a stall: nothing moves.
            if (bus.i_w_valid) begin
               work_d = round_out;
               t_d    = t_q + 6'd1;
               if (t_q == LAST_ROUND) begin
                  state_d = ST_ADD;
                  ready_d = 1'b0;
               end
            end
         end
         ST_ADD: begin
            hash_d  = hash_sum;
            we_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         t_q     <= 6'd0;
         work_q  <= '0;
         h_q     <= '0;
         hash_q  <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         work_q  <= work_d;
         h_q     <= h_d;
         hash_q  <= hash_d;
         we_q    <= we_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign bus.o_w_ready = ready_q;
   assign bus.o_round   = t_q;
   assign bus.o_hash    = hash_q;
   assign bus.o_hash_we = we_q;
   assign bus.o_done    = done_q;
   assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: known-answer digests plus randomized blocks
// checked against a textbook SHA-256 compression model.
module tb_sha256_compress;
   import sha256_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_compress_if bus ();

   sha256_compress #(.DATA_WIDTH(32), .ROUNDS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] M_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] M_TWO2  = {480'h0, 32'h000001c0};

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] w_tb [64];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Expand W0..W15 into the full 64-word message schedule.
   task automatic build_schedule();
      for (int t = 16; t < 64; t++) begin
         w_tb[t] = (ror(w_tb[t-2], 17) ^ ror(w_tb[t-2], 19) ^ (w_tb[t-2] >> 10)) + w_tb[t-7]
                 + (ror(w_tb[t-15], 7) ^ ror(w_tb[t-15], 18) ^ (w_tb[t-15] >> 3)) + w_tb[t-16];
      end
   endtask

   task automatic set_msg(input logic [511:0] m);
      for (int i = 0; i < 16; i++) w_tb[i] = m[511-32*i -: 32];
      build_schedule();
   endtask

   function automatic logic [255:0] ref_compress(input logic [255:0] hin);
      logic [31:0]  v [8];
      logic [31:0]  t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w_tb[t];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_hash"},  bus.o_hash, 256'd0);
      check_eq({tag, "_we"},    256'(bus.o_hash_we), 256'd0);
      check_eq({tag, "_done"},  256'(bus.o_done), 256'd0);
      check_eq({tag, "_busy"},  256'(bus.o_busy), 256'd0);
      check_eq({tag, "_ready"}, 256'(bus.o_w_ready), 256'd0);
      check_eq({tag, "_round"}, 256'(bus.o_round), 256'd0);
   endtask

   // Runs one block starting from the current cycle (entered #1 after an edge).
   // Returns in the o_done cycle, or after an aborting reset when idx hits abort_at.
   task automatic run_block(input string name, input logic [255:0] hin, input int gap_pct,
                            input int start_at, input int abort_at,
                            output logic [255:0] dig, output int lat, output int stalls);
      int idx;
      int cyc;
      bit valid;
      dig    = '0;
      lat    = 0;
      stalls = 0;
      bus.i_hash    = hin;
      bus.i_start   = 1'b1;
      bus.i_w_valid = 1'b1;
      bus.i_w       = $urandom();
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_hash  = rand256();
      cyc = 1;
      idx = 0;
      check_eq({name, "_busy_s1"},  256'(bus.o_busy), 256'd1);
      check_eq({name, "_ready_s1"}, 256'(bus.o_w_ready), 256'd1);
      while (1) begin
         if (idx == abort_at) begin
            bus.i_start = 1'b0;
            rst_n = 1'b0;
            #1;
            check_idle_zero({name, "_abort"});
            repeat (3) begin
               @(posedge clk); #1;
               check_eq({name, "_we_in_reset"}, 256'(bus.o_hash_we), 256'd0);
            end
            rst_n = 1'b1;
            $display("block %s: aborted by reset at round %0d", name, idx);
            return;
         end
         if (idx < 64) check_eq({name, "_round_idx"}, 256'(bus.o_round), 256'(idx));
         if (idx == start_at) begin
            bus.i_start = 1'b1;
            bus.i_hash  = rand256();
         end else begin
            bus.i_start = 1'b0;
         end
         valid = (idx < 64) ? ($urandom_range(0, 99) >= gap_pct) : 1'b1;
         if (!valid) stalls++;
         bus.i_w_valid = valid;
         bus.i_w       = (valid && idx < 64) ? w_tb[idx] : $urandom();
         @(posedge clk); #1;
         if (valid && idx < 64) idx++;
         cyc++;
         if (bus.o_hash_we) break;
         if (cyc > 400) begin
            check_eq({name, "_timeout"}, 256'(cyc), 256'd0);
            return;
         end
      end
      bus.i_start = 1'b0;
      lat = cyc;
      dig = bus.o_hash;
      check_eq({name, "_done_with_we"}, 256'(bus.o_done), 256'd1);
      check_eq({name, "_busy_at_done"}, 256'(bus.o_busy), 256'd0);
      $display("block %s: digest %h latency %0d stalls %0d", name, dig, lat, stalls);
   endtask

   // Strobe must last one cycle and the hash must hold afterwards.
   task automatic check_after_done(input string name, input logic [255:0] dig);
      @(posedge clk); #1;
      check_eq({name, "_we_1cyc"},   256'(bus.o_hash_we), 256'd0);
      check_eq({name, "_done_1cyc"}, 256'(bus.o_done), 256'd0);
      check_eq({name, "_hash_hold"}, bus.o_hash, dig);
   endtask

   initial begin
      logic [255:0] dig;
      logic [255:0] dig1;
      logic [255:0] exp;
      int           lat;
      int           st;

      bus.i_start   = 1'b0;
      bus.i_hash    = '0;
      bus.i_w       = '0;
      bus.i_w_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst_n = 1'b1;

      // Valid words offered in IDLE must not be consumed.
      bus.i_w_valid = 1'b1;
      bus.i_w       = $urandom();
      repeat (4) @(posedge clk);
      #1;
      check_idle_zero("idle_valid");

      set_msg(M_EMPTY);
      exp = ref_compress(IV);
      run_block("empty", IV, 0, -1, -1, dig, lat, st);
      check_eq("empty_digest", dig, D_EMPTY);
      check_eq("empty_model", dig, exp);
      check_eq("empty_latency", 256'(lat), 256'd66);
      check_after_done("empty", dig);

      set_msg(M_ABC);
      run_block("abc", IV, 0, -1, -1, dig, lat, st);
      check_eq("abc_digest", dig, D_ABC);
      check_eq("abc_latency", 256'(lat), 256'd66);
      check_after_done("abc", dig);

      // Two blocks, second started in the o_done cycle of the first.
      set_msg(M_TWO1);
      exp = ref_compress(IV);
      run_block("two_b1", IV, 0, -1, -1, dig1, lat, st);
      check_eq("two_b1_model", dig1, exp);
      set_msg(M_TWO2);
      exp = ref_compress(dig1);
      run_block("two_b2", dig1, 0, -1, -1, dig, lat, st);
      check_eq("two_digest", dig, D_TWO);
      check_eq("two_model", dig, exp);
      check_eq("two_b2_latency", 256'(lat), 256'd66);
      check_after_done("two", dig);

      set_msg(M_ABC);
      run_block("abc_gaps", IV, 40, -1, -1, dig, lat, st);
      check_eq("gaps_digest", dig, D_ABC);
      check_eq("gaps_latency", 256'(lat), 256'(66 + st));
      check_after_done("gaps", dig);

      run_block("abc_restart", IV, 0, 10, -1, dig, lat, st);
      check_eq("restart_digest", dig, D_ABC);
      check_eq("restart_latency", 256'(lat), 256'd66);
      check_after_done("restart", dig);

      run_block("abc_reset", IV, 0, -1, 30, dig, lat, st);
      @(posedge clk); #1;
      check_idle_zero("post_reset");
      run_block("abc_fresh", IV, 0, -1, -1, dig, lat, st);
      check_eq("fresh_digest", dig, D_ABC);
      check_after_done("fresh", dig);

      for (int n = 0; n < 4; n++) begin
         logic [255:0] hin;
         hin = rand256();
         for (int i = 0; i < 16; i++) w_tb[i] = $urandom();
         build_schedule();
         exp = ref_compress(hin);
         run_block("random", hin, 20, -1, -1, dig, lat, st);
         check_eq("random_digest", dig, exp);
         check_eq("random_latency", 256'(lat), 256'(66 + st));
         check_after_done("random", dig);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
